// File: rtl/ps2_coco_keyboard.sv
// ----------------------------------------------------------------------------
// ps2_coco_keyboard
//
// Converts set-2 scancodes from a PS/2 keyboard into the 7x8 CoCo key matrix
// and answers column strobes from the keyboard PIA with active-low row senses.
//
// Ports:
//   clk           system clock
//   rst           synchronous, active-high reset
//   ps2_clk_i     raw keyboard clock (asynchronous)
//   ps2_data_i    raw keyboard data (asynchronous)
//   col_strobe_i  active-low column select from the PIA port B outputs
//   row_out_o     active-low row sense to the PIA port A inputs (combinational)
//   key_event_o   one-cycle pulse when a mapped make/break updates the matrix
//   frame_err_o   one-cycle pulse when a received frame is rejected
// ----------------------------------------------------------------------------
module ps2_coco_keyboard #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 20000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk_i,
   input  logic       ps2_data_i,
   input  logic [7:0] col_strobe_i,
   output logic [6:0] row_out_o,
   output logic       key_event_o,
   output logic       frame_err_o
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_EXT     = 3'd1,
      ST_BRK     = 3'd2,
      ST_EXT_BRK = 3'd3,
      ST_SKIP    = 3'd4
   } state_t;

   // Odd parity: data bits plus parity bit must carry an odd number of ones.
   function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
      odd_parity_ok = ((^d) ^ p) == 1'b1;
   endfunction

   // Keyboard housekeeping bytes that carry no key information.
   function automatic logic is_ignored(input logic [7:0] b);
      case (b)
         8'hAA, 8'hFA, 8'hEE, 8'hFC, 8'hFE, 8'h00, 8'hFF: is_ignored = 1'b1;
         default:                                          is_ignored = 1'b0;
      endcase
   endfunction

   // Scancode to matrix index {hit, row*8+col}. SHIFT (12/59) is handled by
   // separate flags so that it is absent here.
   function automatic logic [6:0] map_key(input logic ext, input logic [7:0] code);
      case ({ext, code})
         9'h054: map_key = {1'b1, 6'd0};   9'h01C: map_key = {1'b1, 6'd1};
         9'h032: map_key = {1'b1, 6'd2};   9'h021: map_key = {1'b1, 6'd3};
         9'h023: map_key = {1'b1, 6'd4};   9'h024: map_key = {1'b1, 6'd5};
         9'h02B: map_key = {1'b1, 6'd6};   9'h034: map_key = {1'b1, 6'd7};
         9'h033: map_key = {1'b1, 6'd8};   9'h043: map_key = {1'b1, 6'd9};
         9'h03B: map_key = {1'b1, 6'd10};  9'h042: map_key = {1'b1, 6'd11};
         9'h04B: map_key = {1'b1, 6'd12};  9'h03A: map_key = {1'b1, 6'd13};
         9'h031: map_key = {1'b1, 6'd14};  9'h044: map_key = {1'b1, 6'd15};
         9'h04D: map_key = {1'b1, 6'd16};  9'h015: map_key = {1'b1, 6'd17};
         9'h02D: map_key = {1'b1, 6'd18};  9'h01B: map_key = {1'b1, 6'd19};
         9'h02C: map_key = {1'b1, 6'd20};  9'h03C: map_key = {1'b1, 6'd21};
         9'h02A: map_key = {1'b1, 6'd22};  9'h01D: map_key = {1'b1, 6'd23};
         9'h022: map_key = {1'b1, 6'd24};  9'h035: map_key = {1'b1, 6'd25};
         9'h01A: map_key = {1'b1, 6'd26};  9'h175: map_key = {1'b1, 6'd27};
         9'h172: map_key = {1'b1, 6'd28};  9'h16B: map_key = {1'b1, 6'd29};
         9'h174: map_key = {1'b1, 6'd30};  9'h029: map_key = {1'b1, 6'd31};
         9'h045: map_key = {1'b1, 6'd32};  9'h016: map_key = {1'b1, 6'd33};
         9'h01E: map_key = {1'b1, 6'd34};  9'h026: map_key = {1'b1, 6'd35};
         9'h025: map_key = {1'b1, 6'd36};  9'h02E: map_key = {1'b1, 6'd37};
         9'h036: map_key = {1'b1, 6'd38};  9'h03D: map_key = {1'b1, 6'd39};
         9'h03E: map_key = {1'b1, 6'd40};  9'h046: map_key = {1'b1, 6'd41};
         9'h052: map_key = {1'b1, 6'd42};  9'h04C: map_key = {1'b1, 6'd43};
         9'h041: map_key = {1'b1, 6'd44};  9'h04E: map_key = {1'b1, 6'd45};
         9'h049: map_key = {1'b1, 6'd46};  9'h04A: map_key = {1'b1, 6'd47};
         9'h05A: map_key = {1'b1, 6'd48};  9'h16C: map_key = {1'b1, 6'd49};
         9'h076: map_key = {1'b1, 6'd50};
         default: map_key = 7'd0;
      endcase
   endfunction

   // Input conditioning
   logic [1:0]    clk_sync_q, data_sync_q;
   logic          clk_filt_q, clk_filt_d, data_filt_q, data_filt_d;
   logic [FW-1:0] clk_cnt_q, clk_cnt_d, data_cnt_q, data_cnt_d;
   logic          clk_prev_q;
   logic          fall_s;

   // Receiver
   logic [3:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_q, par_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          byte_done_s, byte_bad_s;

   // Decoder and matrix
   state_t        state_q;
   logic [2:0]    skip_q;
   logic [54:0]   matrix_q;
   logic          shift_l_q, shift_r_q;
   logic          key_event_q, frame_err_q;
   logic          ext_s, brk_s, act_s, key_act_s, hit_s, lsh_s, rsh_s, event_s;
   logic [6:0]    map_s;
   logic [55:0]   matrix_s;
   logic [6:0]    row_sense_s;

   // Two-flop synchronizers on the raw keyboard lines (idle high)
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_sync_q  <= 2'b11;
         data_sync_q <= 2'b11;
      end else begin
         clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
         data_sync_q <= {data_sync_q[0], ps2_data_i};
      end
   end

   // Glitch filters: a line only changes after FILTER_LEN disagreeing samples in a row
   always_comb begin
      clk_filt_d  = clk_filt_q;
      data_filt_d = data_filt_q;
      if (clk_sync_q[1] != clk_filt_q) begin
         if (clk_cnt_q == FW'(FILTER_LEN - 1)) begin
            clk_filt_d = clk_sync_q[1];
            clk_cnt_d  = '0;
         end else begin
            clk_cnt_d  = clk_cnt_q + FW'(1);
         end
      end else begin
         clk_cnt_d = '0;
      end
      if (data_sync_q[1] != data_filt_q) begin
         if (data_cnt_q == FW'(FILTER_LEN - 1)) begin
            data_filt_d = data_sync_q[1];
            data_cnt_d  = '0;
         end else begin
            data_cnt_d  = data_cnt_q + FW'(1);
         end
      end else begin
         data_cnt_d = '0;
      end
   end

   // Filter state and falling-edge history
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_filt_q  <= 1'b1;
         data_filt_q <= 1'b1;
         clk_cnt_q   <= '0;
         data_cnt_q  <= '0;
         clk_prev_q  <= 1'b1;
      end else begin
         clk_filt_q  <= clk_filt_d;
         data_filt_q <= data_filt_d;
         clk_cnt_q   <= clk_cnt_d;
         data_cnt_q  <= data_cnt_d;
         clk_prev_q  <= clk_filt_q;
      end
   end

   assign fall_s = clk_prev_q & ~clk_filt_q;

   // Frame receiver: start, 8 data LSB first, odd parity, stop; idle timeout
   always_comb begin
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      par_d       = par_q;
      tmo_d       = tmo_q;
      byte_done_s = 1'b0;
      byte_bad_s  = 1'b0;
      if (fall_s) begin
         tmo_d = '0;
         case (bit_cnt_q)
            4'd0: begin
               if (!data_filt_q) begin
                  bit_cnt_d = 4'd1;
               end else begin
                  byte_bad_s = 1'b1;
               end
            end
            4'd9: begin
               par_d     = data_filt_q;
               bit_cnt_d = 4'd10;
            end
            4'd10: begin
               bit_cnt_d = 4'd0;
               if (data_filt_q && odd_parity_ok(shift_q, par_q)) begin
                  byte_done_s = 1'b1;
               end else begin
                  byte_bad_s = 1'b1;
               end
            end
            4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8: begin
               shift_d   = {data_filt_q, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 4'd1;
            end
            default: begin
               bit_cnt_d = 4'd0;
            end
         endcase
      end else if (bit_cnt_q == 4'd0) begin
         tmo_d = '0;
      end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
         tmo_d     = '0;
         bit_cnt_d = 4'd0;
      end else begin
         tmo_d = tmo_q + TW'(1);
      end
   end

   // Receiver state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt_q <= 4'd0;
         shift_q   <= 8'd0;
         par_q     <= 1'b0;
         tmo_q     <= '0;
      end else begin
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         par_q     <= par_d;
         tmo_q     <= tmo_d;
      end
   end

   // Classify the completed byte as a key action given the current prefix state
   always_comb begin
      ext_s = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
      brk_s = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
      case (state_q)
         ST_IDLE:            act_s = (shift_q != 8'hE0) && (shift_q != 8'hF0) &&
                                     (shift_q != 8'hE1) && !is_ignored(shift_q);
         ST_EXT:             act_s = (shift_q != 8'hF0);
         ST_BRK, ST_EXT_BRK: act_s = 1'b1;
         default:            act_s = 1'b0;
      endcase
      key_act_s = byte_done_s && act_s;
      map_s     = map_key(ext_s, shift_q);
      hit_s     = key_act_s && map_s[6];
      lsh_s     = key_act_s && !ext_s && (shift_q == 8'h12);
      rsh_s     = key_act_s && !ext_s && (shift_q == 8'h59);
      event_s   = hit_s || lsh_s || rsh_s;
   end

   // Decoder FSM: tracks E0/F0 prefixes and skips the Pause sequence
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         skip_q  <= 3'd0;
      end else if (byte_done_s) begin
         case (state_q)
            ST_IDLE: begin
               if (shift_q == 8'hE0) begin
                  state_q <= ST_EXT;
               end else if (shift_q == 8'hF0) begin
                  state_q <= ST_BRK;
               end else if (shift_q == 8'hE1) begin
                  state_q <= ST_SKIP;
                  skip_q  <= 3'd7;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_EXT: begin
               state_q <= (shift_q == 8'hF0) ? ST_EXT_BRK : ST_IDLE;
            end
            ST_BRK, ST_EXT_BRK: begin
               state_q <= ST_IDLE;
            end
            ST_SKIP: begin
               skip_q  <= skip_q - 3'd1;
               state_q <= (skip_q <= 3'd1) ? ST_IDLE : ST_SKIP;
            end
            default: begin
               state_q <= ST_IDLE;
               skip_q  <= 3'd0;
            end
         endcase
      end else begin
         state_q <= state_q;
      end
   end

   // Key matrix, shift flags and the registered event pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         matrix_q    <= 55'd0;
         shift_l_q   <= 1'b0;
         shift_r_q   <= 1'b0;
         key_event_q <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         if (hit_s) begin
            matrix_q[map_s[5:0]] <= !brk_s;
         end
         if (lsh_s) begin
            shift_l_q <= !brk_s;
         end
         if (rsh_s) begin
            shift_r_q <= !brk_s;
         end
         key_event_q <= event_s;
         frame_err_q <= byte_bad_s;
      end
   end

   // SHIFT (6:7) is pressed while either physical shift key is held
   assign matrix_s = {shift_l_q | shift_r_q, matrix_q};

   // Row sense: a row is pulled low by any pressed key in a strobed column
   always_comb begin
      for (int r = 0; r < 7; r++) begin
         row_sense_s[r] = |(matrix_s[r*8 +: 8] & ~col_strobe_i);
      end
   end

   assign row_out_o   = ~row_sense_s;
   assign key_event_o = key_event_q;
   assign frame_err_o = frame_err_q;

endmodule
